ahb_led_pwm: RTL and testbench
==============================

# ahb_led_pwm

AHB-Lite slave driving a parametrised bank of LED outputs, each channel independently static or pulse-width modulated. A global enable, a shared prescaler and per-channel duty registers replace the single 8-bit write-only-level LED register of the previous generation. Duty updates are double-buffered so a new duty never glitches mid-period. The block sits on the Cortex-M0 AHB-Lite bus behind the system decoder, alongside the other zero-wait-state peripherals.

## Interface
- NUM_LED, 8, number of LED channels (1..16)
- PWM_BITS, 8, PWM counter and duty width (2..16); period is 2^PWM_BITS ticks
- PRESCALE_BITS, 16, prescaler register width (1..32)
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select from decoder
- HREADY  in  1  bus ready; address phase sampled only when high
- HADDR  in  32  address; only HADDR[7:2] decoded
- HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) marks a valid transfer
- HWRITE  in  1  1 = write
- HSIZE  in  3  ignored; every access treated as 32-bit
- HWDATA  in  32  write data, data phase
- HREADYOUT  out  1  constant 1 (zero wait states)
- HRESP  out  1  constant 0 (OKAY)
- HRDATA  out  32  read data, data phase
- LED  out  NUM_LED  registered LED drive, 1 = on

## Operation
- Address phase: when HREADY=1, register valid = HSEL & HTRANS[1], write flag and word offset HADDR[7:2]. When HREADY=0, the registered values hold.
- Register map (byte offset); unused upper bits read 0 and ignore writes:
  - 0x00 CTRL: bit0 EN.
  - 0x04 PRESCALE[PRESCALE_BITS-1:0].
  - 0x08 MODE[NUM_LED-1:0]: 0 = static, 1 = PWM.
  - 0x0C STATIC[NUM_LED-1:0]: level for static channels.
  - 0x10+4*i DUTY_i[PWM_BITS-1:0], i = 0..NUM_LED-1 (shadow register).
  - Any other offset, or DUTY index >= NUM_LED: reads 0, writes dropped, still OKAY.
- Write: at the clock edge ending the data phase, the target register <= HWDATA (masked to width).
- Read: HRDATA is combinational from the registered offset in the data phase. DUTY reads return the shadow. HRDATA = 0 when the registered valid is 0.
- Prescaler pre_cnt: when EN=1 it increments each cycle. When pre_cnt >= PRESCALE, it asserts tick and reloads 0. The >= comparison makes a PRESCALE reduction take effect at once.
- PWM counter pwm_cnt: increments on tick, wrapping from 2^PWM_BITS-1 to 0.
- Active duty act_i:
  - When EN=0, act_i <= DUTY_i every cycle.
  - When EN=1, act_i <= DUTY_i only on a tick with pwm_cnt = 2^PWM_BITS-1 (period boundary).
- EN=0: pre_cnt and pwm_cnt are held at 0.
- LED next value per channel:
  - MODE_i=0: STATIC_i, regardless of EN.
  - MODE_i=1: EN & (pwm_cnt < act_i).
  - DUTY 0 = always off. DUTY 2^PWM_BITS-1 = on for all but one tick per period.

## Timing
- Reset: all registers, pre_cnt, pwm_cnt and act_i are 0; LED = 0; HRDATA = 0; HREADYOUT = 1; HRESP = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). Counting restarts from 0 after release once EN is rewritten.
- LED latency: a register write commits at edge E; LED reflects it at edge E+1.
- Back-to-back write then read of the same register returns the new value. The read data phase follows the write commit edge.
- A write stalled by HREADY=0 in its data phase commits at the edge where the wait ends. HWDATA is sampled at that edge.
- PWM period = (PRESCALE+1) * 2^PWM_BITS HCLK cycles. On-time = (PRESCALE+1) * act_i cycles.
- Simultaneous DUTY write and period boundary in the same cycle: the boundary loads the old shadow, and the new value applies at the next boundary.
- EN 1->0: LED for PWM channels goes 0 one cycle after the commit.
- EN 0->1: the period starts at pwm_cnt = 0 with act_i = the current shadow.

## Test plan
- Reset: hold HRESETn low, then release -> LED=0, all reads return 0, HREADYOUT=1, HRESP=0.
- Static: write STATIC=0xA5, MODE=0, EN=0 -> LED=0xA5 one cycle after commit; read 0x0C returns 0x000000A5; idle transfers (HTRANS=0) change nothing.
- PWM: NUM_LED=8, PWM_BITS=8, PRESCALE=0, MODE=0x01, DUTY_0=64, EN=1 -> LED[0] high exactly 64 of every 256 cycles, measured over 4 periods; DUTY_0=0 and DUTY_0=255 give 0 and 255 high cycles.
- Shadow: write DUTY_0=200 at pwm_cnt=100 -> current period keeps 64 high cycles, next period has 200; read DUTY_0 returns 200 immediately.
- Prescale and enable: PRESCALE=3 -> period 1024 cycles, LED[0] high 256 cycles; clearing EN mid-period -> LED[0]=0 next cycle and pwm_cnt=0; assert HRESETn mid-period -> LED=0 immediately.
- Bus edges: write stalled by HREADY=0 for 3 cycles commits the final HWDATA; write to 0x40 (unmapped, NUM_LED=8) is dropped, reads back 0, HRESP=0; write then read at offset 0x04 back-to-back returns the new value.

Source files
------------

// File: rtl/ahb_led_pwm.sv
// AHB-Lite LED bank controller: per-channel static level or PWM with shared prescaler.
// Duty registers are shadows; the active duty is loaded only at period boundaries.
module ahb_led_pwm #(
  parameter int unsigned NUM_LED       = 8,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESCALE_BITS = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic               HREADY,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [31:0]        HRDATA,
  output logic [NUM_LED-1:0] LED
);

  logic                     valid_q, write_q;
  logic [5:0]               addr_q;
  logic                     en_q;
  logic [PRESCALE_BITS-1:0] prescale_q, pre_cnt_q;
  logic [NUM_LED-1:0]       mode_q, static_q, led_q, led_d;
  logic [PWM_BITS-1:0]      duty_q [NUM_LED];
  logic [PWM_BITS-1:0]      act_q  [NUM_LED];
  logic [PWM_BITS-1:0]      pwm_cnt_q;
  logic                     wr_en, tick, boundary;
  logic [31:0]              rdata;
  logic                     unused_bits;

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign unused_bits = ^{HSIZE, HADDR[31:8], HADDR[1:0], HTRANS[0], HWDATA};

  // Address phase capture; holds while another slave stalls the bus.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else if (HREADY) begin
      valid_q <= HSEL & HTRANS[1];
      write_q <= HWRITE;
      addr_q  <= HADDR[7:2];
    end
  end

  assign wr_en = valid_q & write_q & HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q       <= 1'b0;
      prescale_q <= '0;
      mode_q     <= '0;
      static_q   <= '0;
      for (int i = 0; i < NUM_LED; i++) duty_q[i] <= '0;
    end else if (wr_en) begin
      case (addr_q)
        6'd0: en_q       <= HWDATA[0];
        6'd1: prescale_q <= HWDATA[PRESCALE_BITS-1:0];
        6'd2: mode_q     <= HWDATA[NUM_LED-1:0];
        6'd3: static_q   <= HWDATA[NUM_LED-1:0];
        default: begin
          for (int i = 0; i < NUM_LED; i++) begin
            if (addr_q == 6'(i + 4)) duty_q[i] <= HWDATA[PWM_BITS-1:0];
          end
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (valid_q) begin
      case (addr_q)
        6'd0: rdata[0]                 = en_q;
        6'd1: rdata[PRESCALE_BITS-1:0] = prescale_q;
        6'd2: rdata[NUM_LED-1:0]       = mode_q;
        6'd3: rdata[NUM_LED-1:0]       = static_q;
        default: begin
          for (int i = 0; i < NUM_LED; i++) begin
            if (addr_q == 6'(i + 4)) rdata[PWM_BITS-1:0] = duty_q[i];
          end
        end
      endcase
    end
  end

  assign HRDATA = rdata;

  // >= rather than == so lowering PRESCALE never waits for a counter wrap.
  assign tick     = en_q && (pre_cnt_q >= prescale_q);
  assign boundary = tick && (pwm_cnt_q == '1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else if (!en_q) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else if (tick) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end else begin
      pre_cnt_q <= pre_cnt_q + 1'b1;
    end
  end

  // While disabled the active duty tracks the shadow so enabling starts with it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_LED; i++) act_q[i] <= '0;
    end else if (!en_q || boundary) begin
      for (int i = 0; i < NUM_LED; i++) act_q[i] <= duty_q[i];
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      led_d[i] = mode_q[i] ? (en_q && (pwm_cnt_q < act_q[i])) : static_q[i];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) led_q <= '0;
    else          led_q <= led_d;
  end

  assign LED = led_q;

endmodule

// File: tb/tb_ahb_led_pwm.sv
// Randomised bus stimulus against a register-file model; reads checked from a scoreboard queue.
module tb_ahb_led_pwm;
  localparam int NL  = 8;
  localparam int PB  = 8;
  localparam int PSB = 16;

  logic        HCLK, HRESETn, HSEL, HREADY, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADYOUT, HRESP;
  logic [NL-1:0] LED;

  ahb_led_pwm #(.NUM_LED(NL), .PWM_BITS(PB), .PRESCALE_BITS(PSB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .LED(LED)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_reg [64];   // register file model indexed by word offset

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int w);
    if (w == 0) return 32'h1;
    if (w == 1) return (32'd1 << PSB) - 1;
    if (w == 2 || w == 3) return (32'd1 << NL) - 1;
    if (w >= 4 && w < 4 + NL) return (32'd1 << PB) - 1;
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return m_reg[int'(a[7:2])];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    m_reg[int'(a[7:2])] = d & mask_of(int'(a[7:2]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_reg[i] = 32'h0;
  endtask

  function automatic logic [7:0] static_led();
    logic [31:0] s, m;
    s = m_reg[3];
    m = m_reg[2];
    return s[7:0] & ~m[7:0];
  endfunction

  // Monitor: mirrors the bus pipeline to know when a read data phase is on the bus.
  logic rd_pend, any_pend;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_pend  <= 1'b0;
      any_pend <= 1'b0;
    end else if (HREADY) begin
      any_pend <= HSEL & HTRANS[1];
      rd_pend  <= HSEL & HTRANS[1] & ~HWRITE;
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn && HREADY) begin
      if (rd_pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: read data phase 0x%08h with empty scoreboard", HRDATA);
        end else begin
          check("hrdata", HRDATA, exp_q.pop_front());
          check("hreadyout", 32'(HREADYOUT), 32'd1);
          check("hresp", 32'(HRESP), 32'd0);
        end
      end else if (!any_pend) begin
        check("hrdata_idle", HRDATA, 32'h0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    step(1);
    idle();
    HWDATA = d;
    model_write(a, d);
    step(1);
  endtask

  task automatic rd(input logic [31:0] a);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    exp_q.push_back(model_read(a));
    step(1);
    idle();
    step(1);
  endtask

  task automatic wr_rd(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    step(1);
    HWRITE = 1'b0;
    HWDATA = d;
    model_write(a, d);
    exp_q.push_back(model_read(a));
    step(1);
    idle();
    step(1);
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin
      if (LED[0]) c++;
      step(1);
    end
  endtask

  task automatic find_rise();
    logic prev;
    int   n;
    prev = LED[0];
    n = 0;
    while (n < 5000) begin
      step(1);
      if (!prev && LED[0]) return;
      prev = LED[0];
      n++;
    end
    checks++;
    errors++;
    $display("FAIL find_rise: LED[0] never rose within 5000 cycles");
  endtask

  int c1, c2;
  logic [31:0] a, d;
  int w, op;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    HRESETn = 1'b0; HREADY = 1'b1; HSIZE = 3'b010; HWDATA = 32'h0;
    idle();
    step(3);
    check("rst_led", 32'(LED), 32'h0);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    step(1);
    for (int i = 0; i < 16; i++) rd(32'(i * 4));

    // Static mode and LED latency
    wr(32'h08, 32'h0);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'hA5);
    check("static_latency", 32'(LED), 32'h0);
    step(1);
    check("static_led", 32'(LED), 32'hA5);
    rd(32'h0C);
    // Idle and unselected transfers must not write
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h0C;
    step(1);
    HWDATA = 32'hFF; HSEL = 1'b0; HTRANS = 2'b10; HADDR = 32'h0C;
    step(1);
    HWDATA = 32'h00;
    idle();
    step(2);
    check("idle_led", 32'(LED), 32'hA5);
    rd(32'h0C);

    // Random register traffic with EN held at 0
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 2);
      a = $urandom;
      if (op == 0) begin
        w = $urandom_range(1, 63);
        a[7:2] = 6'(w);
        d = $urandom;
        wr(a, d);
        step(1);
        check("rand_led", 32'(LED), 32'(static_led()));
      end else if (op == 1) begin
        rd(a);
      end else begin
        step($urandom_range(1, 3));
      end
    end

    // PWM duty sweep, PRESCALE=0
    wr(32'h0C, 32'h00);
    wr(32'h08, 32'h01);
    wr(32'h04, 32'h0);
    wr(32'h10, 32'd64);
    wr(32'h00, 32'h1);
    step(2);
    count_high(1024, c1);
    check("pwm_duty64", 32'(c1), 32'd256);
    wr(32'h10, 32'd0);
    step(600);
    count_high(1024, c1);
    check("pwm_duty0", 32'(c1), 32'd0);
    wr(32'h10, 32'd255);
    step(600);
    count_high(1024, c1);
    check("pwm_duty255", 32'(c1), 32'd1020);

    // Shadow update mid-period
    wr(32'h10, 32'd64);
    step(600);
    find_rise();
    fork
      begin
        count_high(256, c1);
        count_high(256, c2);
      end
      begin
        step(98);
        wr(32'h10, 32'd200);
        rd(32'h10);
      end
    join
    check("shadow_old_period", 32'(c1), 32'd64);
    check("shadow_new_period", 32'(c2), 32'd200);

    // Prescale
    wr(32'h10, 32'd64);
    wr(32'h04, 32'd3);
    step(2100);
    count_high(2048, c1);
    check("prescale3_high", 32'(c1), 32'd512);

    // Disable mid-period, then re-enable restarts from count 0
    find_rise();
    step(10);
    wr(32'h00, 32'h0);
    check("en_clear_before", 32'(LED[0]), 32'd1);
    step(1);
    check("en_clear_led", 32'(LED[0]), 32'd0);
    step(5);
    wr(32'h00, 32'h1);
    step(1);
    c1 = 0;
    while (LED[0] && c1 < 5000) begin
      c1++;
      step(1);
    end
    check("reenable_first_high", 32'(c1), 32'd256);

    // Write stalled by HREADY=0 for three cycles
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0C;
    step(1);
    idle();
    HREADY = 1'b0; HWDATA = 32'h11;
    step(1);
    HWDATA = 32'h22;
    step(1);
    HWDATA = 32'h33;
    step(1);
    HREADY = 1'b1; HWDATA = 32'h3C;
    model_write(32'h0C, 32'h3C);
    step(1);
    rd(32'h0C);
    check("stall_led", 32'(LED & 8'hFE), 32'h3C);

    // Unmapped write, back-to-back write/read
    wr(32'h40, 32'hDEAD_BEEF);
    check("unmapped_hresp", 32'(HRESP), 32'd0);
    rd(32'h40);
    wr_rd(32'h04, 32'h1234);
    wr(32'h04, 32'h0);

    // Asynchronous reset mid-period
    step(600);
    find_rise();
    step(5);
    HRESETn = 1'b0;
    #1;
    check("async_rst_led", 32'(LED), 32'h0);
    model_reset();
    step(2);
    HRESETn = 1'b1;
    step(1);
    rd(32'h00);
    rd(32'h04);
    rd(32'h08);
    rd(32'h10);
    step(300);
    check("post_rst_led", 32'(LED), 32'h0);

    step(2);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
